// File: rtl/rr_decoder_arbiter.sv
// rtl/rr_decoder_arbiter.sv - four-requester round-robin arbiter with bounded hold
// Produces a registered grant index for a 2-to-4 decoder plus a gated one-hot grant.
module rr_decoder_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [1:0] gnt_idx,
  output logic [3:0] grant,
  output logic       gnt_valid
);

  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] HOLD_MAX_C = CW'(HOLD_MAX);
  localparam logic [CW-1:0] ONE_C      = CW'(1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [1:0]      gnt_idx_q, gnt_idx_d;
  logic [1:0]      last_q, last_d;
  logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [3:0]      others;
  logic [1:0]      pick_idx;

  // Scan base+1, base+2, ... so base itself is considered last.
  function automatic logic [1:0] rr_pick(input logic [3:0] s, input logic [1:0] base);
    logic [1:0] r;
    logic [1:0] idx;
    logic       found;
    r     = base;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = base + 2'(i);
      if (!found && s[idx]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    others     = req & ~(4'b0001 << gnt_idx_q);
    pick_idx   = 2'd0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          pick_idx   = rr_pick(req, last_q);
          state_d    = GRANT;
          gnt_idx_d  = pick_idx;
          last_d     = pick_idx;
          hold_cnt_d = ONE_C;
        end
      end
      GRANT: begin
        if (!req[gnt_idx_q]) begin
          if (|others) begin
            pick_idx   = rr_pick(others, gnt_idx_q);
            gnt_idx_d  = pick_idx;
            last_d     = pick_idx;
            hold_cnt_d = ONE_C;
          end else begin
            state_d    = IDLE;
            hold_cnt_d = '0;
          end
        end else if (hold_cnt_q == HOLD_MAX_C && |others) begin
          pick_idx   = rr_pick(others, gnt_idx_q);
          gnt_idx_d  = pick_idx;
          last_d     = pick_idx;
          hold_cnt_d = ONE_C;
        end else if (hold_cnt_q != HOLD_MAX_C) begin
          hold_cnt_d = hold_cnt_q + ONE_C;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_idx_q  <= 2'd0;
      last_q     <= 2'd3;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = (state_q == GRANT);
  assign grant     = gnt_valid ? (4'b0001 << gnt_idx_q) : 4'b0000;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// tb/tb_rr_decoder_arbiter.sv - directed checks for rr_decoder_arbiter
module tb_rr_decoder_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_a, req_b;
  logic [1:0] idx_a, idx_b;
  logic [3:0] grant_a, grant_b;
  logic       valid_a, valid_b;
  int         n_checks;
  int         n_fail;

  rr_decoder_arbiter #(.HOLD_MAX(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a),
    .gnt_idx(idx_a), .grant(grant_a), .gnt_valid(valid_a)
  );

  rr_decoder_arbiter #(.HOLD_MAX(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b),
    .gnt_idx(idx_b), .grant(grant_b), .gnt_valid(valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    req_a = 4'b0000;
    req_b = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_a = 4'b1111;
    req_b = 4'b1111;
    @(negedge clk);
    n_checks++;
    if (grant_a !== 4'b0000) begin n_fail++; $display("FAIL reset_grant got %b want 0000", grant_a); end
    n_checks++;
    if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_a); end
    n_checks++;
    if (idx_a !== 2'd0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", idx_a); end
    n_checks++;
    if (grant_b !== 4'b0000) begin n_fail++; $display("FAIL reset_grant_b got %b want 0000", grant_b); end
    rst_n = 1'b1;
    req_a = 4'b0000;
    req_b = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_rotation();
    logic [1:0] exp_idx;
    do_reset();
    req_a = 4'b1111;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      exp_idx = 2'(((k - 1) / 8) % 4);
      n_checks++;
      if (grant_a !== (4'b0001 << exp_idx) || idx_a !== exp_idx || valid_a !== 1'b1) begin
        n_fail++;
        $display("FAIL rotation cycle %0d got grant=%b idx=%0d valid=%b want grant=%b idx=%0d valid=1",
                 k, grant_a, idx_a, valid_a, 4'b0001 << exp_idx, exp_idx);
      end
    end
  endtask

  task automatic test_lone();
    do_reset();
    req_a = 4'b0100;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      n_checks++;
      if (grant_a !== 4'b0100 || idx_a !== 2'd2) begin
        n_fail++;
        $display("FAIL lone cycle %0d got grant=%b idx=%0d want 0100 idx=2", k, grant_a, idx_a);
      end
    end
    req_a = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (valid_a !== 1'b0 || grant_a !== 4'b0000) begin
      n_fail++;
      $display("FAIL lone_release got valid=%b grant=%b want 0 0000", valid_a, grant_a);
    end
    n_checks++;
    if (idx_a !== 2'd2) begin n_fail++; $display("FAIL idle_idx_hold got %0d want 2", idx_a); end
  endtask

  task automatic test_release_handover();
    do_reset();
    req_a = 4'b0001;
    @(negedge clk);
    req_a = 4'b0010;
    @(negedge clk);
    req_a = 4'b0011;
    @(negedge clk);
    n_checks++;
    if (grant_a !== 4'b0010) begin n_fail++; $display("FAIL handover_owner1 got %b want 0010", grant_a); end
    req_a = 4'b0001;
    @(negedge clk);
    n_checks++;
    if (grant_a !== 4'b0001 || valid_a !== 1'b1) begin
      n_fail++;
      $display("FAIL handover_no_bubble got grant=%b valid=%b want 0001 1", grant_a, valid_a);
    end
    // owner 0 drops while 1 and 3 request: scan starts at 1
    req_a = 4'b1010;
    @(negedge clk);
    n_checks++;
    if (grant_a !== 4'b0010) begin n_fail++; $display("FAIL release_pick_after_owner got %b want 0010", grant_a); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g;
    do_reset();
    req_a = 4'b0100;
    @(negedge clk);
    n_checks++;
    if (grant_a !== 4'b0100) begin n_fail++; $display("FAIL fair_start got %b want 0100", grant_a); end
    req_a = 4'b0101;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      exp_g = (j < 8) ? 4'b0100 : ((j < 16) ? 4'b0001 : 4'b0100);
      n_checks++;
      if (grant_a !== exp_g) begin
        n_fail++;
        $display("FAIL fairness cycle %0d got %b want %b", j, grant_a, exp_g);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req_a = 4'b1000;
    @(negedge clk);
    n_checks++;
    if (grant_a !== 4'b1000) begin n_fail++; $display("FAIL midrst_pre got %b want 1000", grant_a); end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (grant_a !== 4'b0000 || valid_a !== 1'b0 || idx_a !== 2'd0) begin
      n_fail++;
      $display("FAIL midrst_drop got grant=%b valid=%b idx=%0d want 0000 0 0", grant_a, valid_a, idx_a);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (grant_a !== 4'b1000 || idx_a !== 2'd3) begin
      n_fail++;
      $display("FAIL midrst_regrant got grant=%b idx=%0d want 1000 3", grant_a, idx_a);
    end
  endtask

  task automatic test_hold_one();
    logic [3:0] exp_g;
    do_reset();
    req_b = 4'b1010;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      exp_g = (j % 2 == 1) ? 4'b0010 : 4'b1000;
      n_checks++;
      if (grant_b !== exp_g || valid_b !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_one cycle %0d got grant=%b valid=%b want %b 1", j, grant_b, valid_b, exp_g);
      end
    end
    req_b = 4'b0000;
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    req_a    = 4'b0000;
    req_b    = 4'b0000;
    test_reset();
    test_rotation();
    test_lone();
    test_release_handover();
    test_fairness();
    test_reset_mid_grant();
    test_hold_one();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
